demux_dist: RTL and testbench

Registered 1-to-4 data distributor: the inverse of the team's 4:1 selector. It accepts a WIDTH-bit word plus a 2-bit destination select over a valid/ready handshake and routes it into one of four per-channel FIFOs. Each FIFO drains on its own valid/ready output port. The block sits where one shared producer (bus, decoder, test-pattern source) feeds four independent consumers that stall at different rates.

---
 rtl/demux_dist.sv | 86 ++++++++
 tb/tb_demux_dist.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dist.sv
// demux_dist: registered 1-to-4 valid/ready distributor feeding four per-channel FIFOs.
// Define DEMUX_DIST_CNT_EN to build per-channel 8-bit pop counters exposed on out_count.
module demux_dist #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
`ifdef DEMUX_DIST_CNT_EN
    ,
    output logic [31:0]        out_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] OCC_FULL = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [3:0] w_full;
    logic [3:0] w_push;
    logic [3:0] w_pop;

    // A full channel stalls the producer even if its consumer pops this cycle.
    assign in_ready = ~w_full[in_sel];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [PW-1:0]    r_wptr;
            logic [PW-1:0]    r_rptr;
            logic [PW-1:0]    r_occ;

            assign w_full[gi]    = (r_occ == OCC_FULL);
            assign out_valid[gi] = (r_occ != '0);
            assign w_push[gi]    = in_valid & ~w_full[gi] & (in_sel == 2'(gi));
            assign w_pop[gi]     = out_valid[gi] & out_ready[gi];
            assign out_data[gi*WIDTH +: WIDTH] = r_mem[r_rptr[AW-1:0]];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_occ  <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= '0;
                    end
                end else begin
                    if (w_push[gi]) begin
                        r_mem[r_wptr[AW-1:0]] <= in_data;
                        r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PW'(1);
                    end
                    if (w_pop[gi]) begin
                        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PW'(1);
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_occ <= r_occ + PW'(1);
                        2'b01:   r_occ <= r_occ - PW'(1);
                        default: r_occ <= r_occ;
                    endcase
                end
            end

`ifdef DEMUX_DIST_CNT_EN
            logic [7:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_pop[gi]) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end

            assign out_count[gi*8 +: 8] = r_cnt;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_demux_dist.sv
// tb_demux_dist: randomized and directed checks of demux_dist against per-channel queue model.
// Counter checks are built when DEMUX_DIST_CNT_EN is defined.
module tb_demux_dist;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic               clk;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
`ifdef DEMUX_DIST_CNT_EN
    logic [31:0]        out_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] mq [4][$];
    int               pops [4];

    demux_dist #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_DIST_CNT_EN
        ,
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (mq[k].size() != 0);
        return v;
    endfunction

    function automatic logic [4*WIDTH-1:0] exp_data();
        logic [4*WIDTH-1:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) if (mq[k].size() != 0) d[k*WIDTH +: WIDTH] = mq[k][0];
        return d;
    endfunction

    function automatic logic [4*WIDTH-1:0] data_mask();
        logic [4*WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (mq[k].size() != 0) m[k*WIDTH +: WIDTH] = '1;
        return m;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            pops[k] = 0;
        end
    endtask

    // One clock of stimulus; the model advances using its own occupancy, never the DUT's.
    task automatic drive_cycle(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                               input logic [3:0] rdy, output logic rdy_obs, output logic rdy_exp);
        logic [WIDTH-1:0] hd;
        @(negedge clk);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = rdy;
        #1;
        rdy_obs = in_ready;
        rdy_exp = (mq[sel].size() < DEPTH);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (rdy[k] && mq[k].size() != 0) begin
                hd = mq[k].pop_front();
                pops[k]++;
                $display("[%0t] pop  ch%0d data %h", $time, k, hd);
            end
        end
        if (v && rdy_exp) begin
            mq[sel].push_back(d);
            $display("[%0t] push ch%0d data %h", $time, sel, d);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_in_ready sel=%0d got %b want 1", s, in_ready);
            end
        end
        n_cmp++;
        if (out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_out_valid got %b want 0000", out_valid);
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_err++;
            $display("FAIL reset_out_data got %h want 0", out_data);
        end
    endtask

    task automatic test_single_push();
        logic ro, re;
        drive_cycle(1'b1, 2'b10, 4'hA, 4'b0000, ro, re);
        n_cmp++;
        if (ro !== re) begin
            n_err++;
            $display("FAIL single_in_ready got %b want %b", ro, re);
        end
        n_cmp++;
        if (out_valid !== 4'b0100) begin
            n_err++;
            $display("FAIL single_out_valid got %b want 0100", out_valid);
        end
        n_cmp++;
        if (out_data[11:8] !== 4'hA) begin
            n_err++;
            $display("FAIL single_out_data got %h want a", out_data[11:8]);
        end
        drive_cycle(1'b0, 2'b00, 4'h0, 4'b0100, ro, re);
        n_cmp++;
        if (out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL single_drain got %b want 0000", out_valid);
        end
    endtask

    task automatic test_fill_stall();
        logic ro, re;
        drive_cycle(1'b1, 2'b01, 4'h1, 4'b0000, ro, re);
        drive_cycle(1'b1, 2'b01, 4'h2, 4'b0000, ro, re);
        // Full channel 1: third word stalls, with and without a same-cycle pop.
        drive_cycle(1'b1, 2'b01, 4'h3, 4'b0000, ro, re);
        n_cmp++;
        if (ro !== 1'b0 || re !== 1'b0) begin
            n_err++;
            $display("FAIL stall_full got %b want 0", ro);
        end
        drive_cycle(1'b1, 2'b01, 4'h3, 4'b0010, ro, re);
        n_cmp++;
        if (ro !== 1'b0) begin
            n_err++;
            $display("FAIL stall_no_bypass got %b want 0", ro);
        end
        n_cmp++;
        if (out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h2) begin
            n_err++;
            $display("FAIL stall_pop1 got v=%b d=%h want v=1 d=2", out_valid[1], out_data[7:4]);
        end
        drive_cycle(1'b1, 2'b01, 4'h3, 4'b0010, ro, re);
        n_cmp++;
        if (ro !== 1'b1) begin
            n_err++;
            $display("FAIL stall_accept got %b want 1", ro);
        end
        n_cmp++;
        if (out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h3) begin
            n_err++;
            $display("FAIL stall_pop2 got v=%b d=%h want v=1 d=3", out_valid[1], out_data[7:4]);
        end
        drive_cycle(1'b0, 2'b01, 4'h0, 4'b0010, ro, re);
        n_cmp++;
        if (out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL stall_drain got %b want 0000", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic ro, re;
        logic [WIDTH-1:0] w;
        for (int i = 0; i < 8; i++) begin
            w = WIDTH'($urandom);
            drive_cycle(1'b1, 2'b11, w, 4'b1111, ro, re);
            n_cmp++;
            if (ro !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_in_ready word %0d got %b want 1", i, ro);
            end
            n_cmp++;
            if (out_valid !== 4'b1000 || out_data[15:12] !== w) begin
                n_err++;
                $display("FAIL b2b_word %0d got v=%b d=%h want v=1000 d=%h", i, out_valid, out_data[15:12], w);
            end
        end
        drive_cycle(1'b0, 2'b11, 4'h0, 4'b1111, ro, re);
        n_cmp++;
        if (out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL b2b_drain got %b want 0000", out_valid);
        end
    endtask

    task automatic test_sel_switch();
        logic ro, re;
        drive_cycle(1'b1, 2'b00, 4'h5, 4'b0000, ro, re);
        drive_cycle(1'b1, 2'b00, 4'h6, 4'b0000, ro, re);
        drive_cycle(1'b1, 2'b00, 4'h9, 4'b0000, ro, re);
        n_cmp++;
        if (ro !== 1'b0) begin
            n_err++;
            $display("FAIL switch_stalled got %b want 0", ro);
        end
        drive_cycle(1'b1, 2'b11, 4'h9, 4'b0000, ro, re);
        n_cmp++;
        if (ro !== 1'b1) begin
            n_err++;
            $display("FAIL switch_in_ready got %b want 1", ro);
        end
        n_cmp++;
        if (out_valid !== 4'b1001 || out_data[15:12] !== 4'h9 || out_data[3:0] !== 4'h5) begin
            n_err++;
            $display("FAIL switch_route got v=%b d=%h want v=1001 d=9xx5", out_valid, out_data);
        end
        drive_cycle(1'b0, 2'b00, 4'h0, 4'b1001, ro, re);
        drive_cycle(1'b0, 2'b00, 4'h0, 4'b0001, ro, re);
        n_cmp++;
        if (out_valid !== exp_valid() || out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL switch_drain got %b want 0000", out_valid);
        end
    endtask

    task automatic test_async_reset();
        logic ro, re;
        drive_cycle(1'b1, 2'b00, 4'h7, 4'b0000, ro, re);
        drive_cycle(1'b1, 2'b10, 4'hC, 4'b0000, ro, re);
        drive_cycle(1'b1, 2'b00, 4'h8, 4'b0000, ro, re);
        drive_cycle(1'b1, 2'b10, 4'hD, 4'b0000, ro, re);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (out_valid !== 4'b0000 || out_data !== '0) begin
            n_err++;
            $display("FAIL async_reset_outputs got v=%b d=%h want 0", out_valid, out_data);
        end
        in_sel = 2'b00;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_in_ready got %b want 1", in_ready);
        end
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 2'b00, 4'h0, 4'b1111, ro, re);
            n_cmp++;
            if (out_valid !== 4'b0000) begin
                n_err++;
                $display("FAIL async_reset_stale cycle %0d got %b want 0000", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic ro, re;
        for (int i = 0; i < 300; i++) begin
            drive_cycle(($urandom_range(0, 3) != 0), 2'($urandom), WIDTH'($urandom), 4'($urandom), ro, re);
            n_cmp++;
            if (ro !== re) begin
                n_err++;
                $display("FAIL rand_in_ready cycle %0d got %b want %b", i, ro, re);
            end
            n_cmp++;
            if (out_valid !== exp_valid() || (out_data & data_mask()) !== exp_data()) begin
                n_err++;
                $display("FAIL rand_outputs cycle %0d got v=%b d=%h want v=%b d=%h", i, out_valid, out_data & data_mask(), exp_valid(), exp_data());
            end
`ifdef DEMUX_DIST_CNT_EN
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (out_count[k*8 +: 8] !== 8'(pops[k] % 256)) begin
                    n_err++;
                    $display("FAIL rand_count ch%0d got %0d want %0d", k, out_count[k*8 +: 8], pops[k] % 256);
                end
            end
`endif
        end
    endtask

`ifdef DEMUX_DIST_CNT_EN
    task automatic test_counter_wrap();
        logic ro, re;
        int cyc;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        model_clear();
        #2;
        n_cmp++;
        if (out_count !== 32'd0) begin
            n_err++;
            $display("FAIL count_reset got %h want 0", out_count);
        end
        rst_n = 1'b1;
        cyc = 0;
        while (pops[0] < 257 && cyc < 400) begin
            drive_cycle(1'b1, 2'b00, WIDTH'($urandom), 4'b0001, ro, re);
            cyc++;
        end
        n_cmp++;
        if (pops[0] != 257) begin
            n_err++;
            $display("FAIL count_budget got %0d pops want 257", pops[0]);
        end
        n_cmp++;
        if (out_count[7:0] !== 8'd1 || out_count[31:8] !== 24'd0) begin
            n_err++;
            $display("FAIL count_wrap got %h want 00000001", out_count);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'b00;
        in_data   = '0;
        out_ready = 4'b0000;
        model_clear();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_single_push();
        test_fill_stall();
        test_back_to_back();
        test_sel_switch();
        test_async_reset();
        test_random();
`ifdef DEMUX_DIST_CNT_EN
        test_counter_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
